blob_stats_readout: RTL and testbench
=====================================

Name: blob_stats_readout

Overview:
- Downstream consumer of the connected-components labeled pixel stream.
- Accumulates per-label statistics over one frame: area, bounding box, and coordinate sums.
- At end of frame, drains one record per qualifying blob over a valid/ready handshake to the tracking/overlay logic.
- Clears its tables while draining, then re-arms for the next frame.

Parameters:
- HRES, 1280, horizontal resolution; frame-end column is HRES-1
- VRES, 720, vertical resolution; frame-end row is VRES-1
- MAX_LABELS, 64, table entries; labels 1..MAX_LABELS-1 tracked, label 0 is background
- MIN_AREA, 10, minimum area for a record to be emitted; a value of 0 is treated as 1

Ports:
- clk_in  input  1  system clock
- rst_n_in  input  1  asynchronous active-low reset
- label_in  input  16  pixel label, 0 = background
- hcount_in  input  11  pixel column
- vcount_in  input  10  pixel row
- valid_in  input  1  pixel qualifier
- blob_valid_out  output  1  record valid
- blob_ready_in  input  1  consumer ready
- blob_label_out  output  16  record label
- blob_area_out  output  20  pixel count
- blob_xmin_out / blob_xmax_out  output  11 each  bounding-box columns
- blob_ymin_out / blob_ymax_out  output  10 each  bounding-box rows
- blob_xsum_out  output  31  sum of hcount
- blob_ysum_out  output  30  sum of vcount
- frame_done_out  output  1  one-cycle pulse after drain completes
- blob_count_out  output  16  records emitted in the last drain
- busy_out  output  1  high in DRAIN state
- label_ovf_out  output  1  sticky per frame: a label ≥ MAX_LABELS was seen
- overrun_out  output  1  sticky until reset: valid pixel arrived during DRAIN

Behaviour:
- Reset (async assert, sync deassert use):
  - state = ACCUM.
  - All table entries cleared: area = 0, sums = 0, xmin = 2047, ymin = 1023, xmax = 0, ymax = 0.
  - All outputs 0.
- Table clear on reset: if a single-cycle clear is impractical, an INIT state clears one entry per cycle for MAX_LABELS cycles. busy_out is high during INIT; pixels arriving in INIT set overrun_out.
- ACCUM, pixel update: on valid_in with 0 < label_in < MAX_LABELS, the entry is updated one cycle later:
  - area += 1
  - min/max updated against hcount_in/vcount_in
  - sums accumulated
- Back-to-back same-label pixels: must accumulate correctly. Use forwarding, or a read-modify-write that needs no stall; there is no backpressure on the pixel stream.
- Labels out of range: label_in == 0 is ignored. label_in ≥ MAX_LABELS is ignored and sets label_ovf_out.
- Frame end: a valid pixel with hcount_in == HRES-1 and vcount_in == VRES-1.
  - That pixel is accumulated.
  - The next cycle enters DRAIN with idx = 1 and blob_count = 0.
  - label_ovf_out holds through DRAIN and clears on return to ACCUM.
- DRAIN scan:
  - Entry idx with area ≥ MIN_AREA: present the record with blob_valid_out = 1. All record fields stay stable until blob_valid_out && blob_ready_in.
  - On handshake: clear the entry, blob_count += 1, idx += 1.
  - Non-qualifying entry: clear it and advance idx in one cycle, with no output.
  - blob_valid_out never drops without a handshake.
- DRAIN exit: after idx = MAX_LABELS-1 is retired, the next cycle pulses frame_done_out, updates blob_count_out, and returns to ACCUM.
  - blob_count_out holds until the next frame_done_out.
  - Frame with no qualifying blobs: exactly MAX_LABELS-1 DRAIN cycles, then frame_done_out with count 0.
- Pixels during DRAIN: dropped, and overrun_out is set. A frame-end pixel in DRAIN is also dropped.
- Reset mid-DRAIN: the record is abandoned, blob_valid_out drops immediately, and the tables are cleared.
- Widths: area saturates at 2^20-1. Sums are sized so no overflow is possible at the default resolution.

Test Plan:
- HRES=8, VRES=4, MIN_AREA=2. Label 3 at (1,0),(2,0),(1,1); blob_ready_in=1 → one record: label 3, area 3, x 1..2, y 0..1, xsum 4, ysum 1. Then frame_done_out with count 1.
- Label 5 on 1 pixel and label 6 on 4 pixels → only label 6 emitted; count 1; a second identical frame gives identical output (tables were cleared).
- Hold blob_ready_in = 0 for 10 cycles with a record pending → blob_valid_out stays high and fields stay stable. Release → handshake completes and the scan proceeds.
- Label 100 with MAX_LABELS=64 → label_ovf_out = 1 through DRAIN, 0 after frame_done_out; no record emitted for it.
- Same label on consecutive cycles across 8 pixels of a row → area 8 (forwarding correct). A valid pixel during DRAIN → overrun_out = 1 and stays set.
- Assert rst_n_in mid-DRAIN with blob_valid_out = 1 → all outputs 0 at once. The next frame reports only that frame's pixels.

Source files
------------

// File: rtl/blob_stats_readout_if.sv
// Labeled pixel stream in, per-blob statistics records out.
// The slave modport is the statistics block; the master side is the pixel source plus the record consumer.
interface blob_stats_readout_if;
  logic [15:0] label_in;
  logic [10:0] hcount_in;
  logic [9:0]  vcount_in;
  logic        valid_in;
  logic        blob_valid_out;
  logic        blob_ready_in;
  logic [15:0] blob_label_out;
  logic [19:0] blob_area_out;
  logic [10:0] blob_xmin_out;
  logic [10:0] blob_xmax_out;
  logic [9:0]  blob_ymin_out;
  logic [9:0]  blob_ymax_out;
  logic [30:0] blob_xsum_out;
  logic [29:0] blob_ysum_out;
  logic        frame_done_out;
  logic [15:0] blob_count_out;
  logic        busy_out;
  logic        label_ovf_out;
  logic        overrun_out;

  modport slave (
    input  label_in, hcount_in, vcount_in, valid_in, blob_ready_in,
    output blob_valid_out, blob_label_out, blob_area_out,
           blob_xmin_out, blob_xmax_out, blob_ymin_out, blob_ymax_out,
           blob_xsum_out, blob_ysum_out, frame_done_out, blob_count_out,
           busy_out, label_ovf_out, overrun_out
  );

  modport master (
    output label_in, hcount_in, vcount_in, valid_in, blob_ready_in,
    input  blob_valid_out, blob_label_out, blob_area_out,
           blob_xmin_out, blob_xmax_out, blob_ymin_out, blob_ymax_out,
           blob_xsum_out, blob_ysum_out, frame_done_out, blob_count_out,
           busy_out, label_ovf_out, overrun_out
  );
endinterface

// File: rtl/blob_stats_readout.sv
// Per-label area / bounding box / coordinate-sum accumulator over one frame,
// drained at frame end as one valid/ready record per blob of sufficient area.
module blob_stats_readout #(
  parameter int unsigned HRES       = 1280,
  parameter int unsigned VRES       = 720,
  parameter int unsigned MAX_LABELS = 64,
  parameter int unsigned MIN_AREA   = 10
) (
  input logic               clk_in,
  input logic               rst_n_in,
  blob_stats_readout_if.slave bus
);

  localparam int unsigned LW      = $clog2(MAX_LABELS);
  localparam logic [19:0] MIN_EFF = (MIN_AREA == 0) ? 20'd1 : 20'(MIN_AREA);

  typedef struct packed {
    logic [19:0] area;
    logic [10:0] xmin;
    logic [10:0] xmax;
    logic [9:0]  ymin;
    logic [9:0]  ymax;
    logic [30:0] xsum;
    logic [29:0] ysum;
  } entry_t;

  localparam entry_t EMPTY = '{area: 20'd0, xmin: 11'h7FF, xmax: 11'd0,
                               ymin: 10'h3FF, ymax: 10'd0, xsum: 31'd0, ysum: 30'd0};

  typedef enum logic {ACCUM, DRAIN} state_t;

  state_t       state;
  entry_t       tbl [MAX_LABELS];
  logic [LW-1:0] idx;
  logic [15:0]  count;

  logic         blob_valid;
  logic [15:0]  blob_label;
  entry_t       rec;
  logic         frame_done;
  logic [15:0]  blob_count;
  logic         busy;
  logic         label_ovf;
  logic         overrun;

  logic [LW-1:0] pix_idx;
  logic          in_range;
  logic          too_big;
  logic          frame_end;
  entry_t        cur;
  entry_t        upd;
  entry_t        scan;
  logic          qualifies;
  logic          handshake;
  logic          retire;
  logic          last;

  assign pix_idx   = bus.label_in[LW-1:0];
  assign too_big   = bus.label_in >= 16'(MAX_LABELS);
  assign in_range  = (bus.label_in != 16'd0) && !too_big;
  assign frame_end = (bus.hcount_in == 11'(HRES - 1)) && (bus.vcount_in == 10'(VRES - 1));
  assign cur       = tbl[pix_idx];
  assign scan      = tbl[idx];
  assign qualifies = scan.area >= MIN_EFF;
  assign handshake = blob_valid && bus.blob_ready_in;
  assign retire    = handshake || (!blob_valid && !qualifies);
  assign last      = idx == LW'(MAX_LABELS - 1);

  // The table is written at the pixel's own clock edge, so a same-label pixel
  // on the next cycle already reads the updated entry; no forwarding needed.
  always_comb begin
    upd = cur;
    if (cur.area != '1) upd.area = cur.area + 20'd1;
    if (bus.hcount_in < cur.xmin) upd.xmin = bus.hcount_in;
    if (bus.hcount_in > cur.xmax) upd.xmax = bus.hcount_in;
    if (bus.vcount_in < cur.ymin) upd.ymin = bus.vcount_in;
    if (bus.vcount_in > cur.ymax) upd.ymax = bus.vcount_in;
    upd.xsum = cur.xsum + 31'(bus.hcount_in);
    upd.ysum = cur.ysum + 30'(bus.vcount_in);
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= ACCUM;
      idx        <= '0;
      count      <= '0;
      for (int unsigned i = 0; i < MAX_LABELS; i++) tbl[i] <= EMPTY;
      blob_valid <= 1'b0;
      blob_label <= '0;
      rec        <= '0;
      frame_done <= 1'b0;
      blob_count <= '0;
      busy       <= 1'b0;
      label_ovf  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ACCUM: begin
          if (bus.valid_in) begin
            if (in_range) tbl[pix_idx] <= upd;
            if (too_big) label_ovf <= 1'b1;
            if (frame_end) begin
              state <= DRAIN;
              busy  <= 1'b1;
              idx   <= LW'(1);
              count <= '0;
            end
          end
        end
        DRAIN: begin
          if (bus.valid_in) overrun <= 1'b1;
          // A record is loaded in one cycle and retired on the handshake, so
          // the output fields are never touched while blob_valid is high.
          if (handshake) begin
            blob_valid <= 1'b0;
          end else if (!blob_valid && qualifies) begin
            blob_valid <= 1'b1;
            blob_label <= 16'(idx);
            rec        <= scan;
          end
          if (retire) begin
            tbl[idx] <= EMPTY;
            idx      <= idx + LW'(1);
            if (handshake) count <= count + 16'd1;
            if (last) begin
              state      <= ACCUM;
              busy       <= 1'b0;
              label_ovf  <= 1'b0;
              frame_done <= 1'b1;
              blob_count <= handshake ? count + 16'd1 : count;
            end
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  assign bus.blob_valid_out = blob_valid;
  assign bus.blob_label_out = blob_label;
  assign bus.blob_area_out  = rec.area;
  assign bus.blob_xmin_out  = rec.xmin;
  assign bus.blob_xmax_out  = rec.xmax;
  assign bus.blob_ymin_out  = rec.ymin;
  assign bus.blob_ymax_out  = rec.ymax;
  assign bus.blob_xsum_out  = rec.xsum;
  assign bus.blob_ysum_out  = rec.ysum;
  assign bus.frame_done_out = frame_done;
  assign bus.blob_count_out = blob_count;
  assign bus.busy_out       = busy;
  assign bus.label_ovf_out  = label_ovf;
  assign bus.overrun_out    = overrun;

endmodule

// File: tb/tb_blob_stats_readout.sv
// Directed bench for blob_stats_readout on an 8x4 frame with MIN_AREA=2.
module tb_blob_stats_readout;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  blob_stats_readout_if bus ();

  blob_stats_readout #(
    .HRES(8), .VRES(4), .MAX_LABELS(64), .MIN_AREA(2)
  ) dut (
    .clk_in(clk),
    .rst_n_in(rst_n),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Records observed during the most recent drain
  int          nrec;
  logic [15:0] rec_label [8];
  logic [19:0] rec_area  [8];
  logic [10:0] rec_xmin  [8];
  logic [10:0] rec_xmax  [8];
  logic [9:0]  rec_ymin  [8];
  logic [9:0]  rec_ymax  [8];
  logic [30:0] rec_xsum  [8];
  logic [29:0] rec_ysum  [8];
  bit          done_seen;
  logic [15:0] done_count;
  int          busy_cycles;
  bit          ovf_dropped;
  logic        ovf_at_done;

  // Called at a negedge; leaves the caller at the following negedge.
  task automatic pix(input logic [15:0] l, input logic [10:0] h, input logic [9:0] v);
    bus.label_in  = l;
    bus.hcount_in = h;
    bus.vcount_in = v;
    bus.valid_in  = 1'b1;
    @(negedge clk);
    bus.valid_in  = 1'b0;
    bus.label_in  = '0;
  endtask

  task automatic run_drain(input int budget);
    nrec = 0; done_seen = 0; busy_cycles = 0; ovf_dropped = 0;
    done_count = 'x; ovf_at_done = 1'bx;
    for (int c = 0; c < budget && !done_seen; c++) begin
      if (bus.busy_out) busy_cycles++;
      if (bus.busy_out && !bus.label_ovf_out) ovf_dropped = 1;
      if (bus.blob_valid_out && bus.blob_ready_in) begin
        if (nrec < 8) begin
          rec_label[nrec] = bus.blob_label_out;
          rec_area[nrec]  = bus.blob_area_out;
          rec_xmin[nrec]  = bus.blob_xmin_out;
          rec_xmax[nrec]  = bus.blob_xmax_out;
          rec_ymin[nrec]  = bus.blob_ymin_out;
          rec_ymax[nrec]  = bus.blob_ymax_out;
          rec_xsum[nrec]  = bus.blob_xsum_out;
          rec_ysum[nrec]  = bus.blob_ysum_out;
        end
        nrec++;
      end
      if (bus.frame_done_out) begin
        done_seen   = 1;
        done_count  = bus.blob_count_out;
        ovf_at_done = bus.label_ovf_out;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset;
    checks++;
    if (bus.blob_valid_out !== 1'b0 || bus.frame_done_out !== 1'b0 || bus.busy_out !== 1'b0 ||
        bus.label_ovf_out !== 1'b0 || bus.overrun_out !== 1'b0 || bus.blob_count_out !== 16'd0 ||
        bus.blob_label_out !== 16'd0 || bus.blob_area_out !== 20'd0) begin
      $display("FAIL reset_outputs valid=%b done=%b busy=%b ovf=%b ovr=%b cnt=%0d lbl=%0d area=%0d expected all 0",
               bus.blob_valid_out, bus.frame_done_out, bus.busy_out, bus.label_ovf_out,
               bus.overrun_out, bus.blob_count_out, bus.blob_label_out, bus.blob_area_out);
      errors++;
    end
  endtask

  task automatic test_single_blob;
    pix(16'd3, 11'd1, 10'd0);
    pix(16'd3, 11'd2, 10'd0);
    pix(16'd3, 11'd1, 10'd1);
    pix(16'd0, 11'd7, 10'd3);
    checks++;
    if (bus.busy_out !== 1'b1) begin
      $display("FAIL busy_after_frame_end got %b expected 1", bus.busy_out); errors++;
    end
    run_drain(300);
    checks++;
    if (!done_seen || done_count !== 16'd1 || nrec != 1) begin
      $display("FAIL single_done seen=%0d count=%0d nrec=%0d expected 1/1/1", done_seen, done_count, nrec); errors++;
    end
    checks++;
    if (rec_label[0] !== 16'd3 || rec_area[0] !== 20'd3 || rec_xmin[0] !== 11'd1 || rec_xmax[0] !== 11'd2 ||
        rec_ymin[0] !== 10'd0 || rec_ymax[0] !== 10'd1 || rec_xsum[0] !== 31'd4 || rec_ysum[0] !== 30'd1) begin
      $display("FAIL single_record got l=%0d a=%0d x=%0d..%0d y=%0d..%0d xs=%0d ys=%0d expected l=3 a=3 x=1..2 y=0..1 xs=4 ys=1",
               rec_label[0], rec_area[0], rec_xmin[0], rec_xmax[0], rec_ymin[0], rec_ymax[0], rec_xsum[0], rec_ysum[0]);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (bus.frame_done_out !== 1'b0 || bus.busy_out !== 1'b0) begin
      $display("FAIL done_pulse_width done=%b busy=%b expected 0/0", bus.frame_done_out, bus.busy_out); errors++;
    end
  endtask

  task automatic test_empty_frame;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.blob_count_out !== 16'd1) begin
      $display("FAIL count_hold got %0d expected 1", bus.blob_count_out); errors++;
    end
    pix(16'd0, 11'd7, 10'd3);
    run_drain(300);
    checks++;
    if (!done_seen || busy_cycles != 63 || done_count !== 16'd0 || nrec != 0) begin
      $display("FAIL empty_frame seen=%0d busy_cycles=%0d count=%0d nrec=%0d expected 1/63/0/0",
               done_seen, busy_cycles, done_count, nrec); errors++;
    end
  endtask

  task automatic test_min_area;
    for (int r = 0; r < 2; r++) begin
      pix(16'd5, 11'd0, 10'd0);
      pix(16'd6, 11'd4, 10'd1);
      pix(16'd6, 11'd5, 10'd1);
      pix(16'd6, 11'd4, 10'd2);
      pix(16'd6, 11'd5, 10'd2);
      pix(16'd0, 11'd7, 10'd3);
      run_drain(300);
      checks++;
      if (!done_seen || done_count !== 16'd1 || nrec != 1) begin
        $display("FAIL min_area_done pass=%0d seen=%0d count=%0d nrec=%0d expected 1/1/1", r, done_seen, done_count, nrec);
        errors++;
      end
      checks++;
      if (rec_label[0] !== 16'd6 || rec_area[0] !== 20'd4 || rec_xmin[0] !== 11'd4 || rec_xmax[0] !== 11'd5 ||
          rec_ymin[0] !== 10'd1 || rec_ymax[0] !== 10'd2 || rec_xsum[0] !== 31'd18 || rec_ysum[0] !== 30'd6) begin
        $display("FAIL min_area_record pass=%0d got l=%0d a=%0d xs=%0d ys=%0d expected l=6 a=4 xs=18 ys=6",
                 r, rec_label[0], rec_area[0], rec_xsum[0], rec_ysum[0]);
        errors++;
      end
    end
  endtask

  task automatic test_backpressure;
    bit seen;
    bus.blob_ready_in = 1'b0;
    pix(16'd2, 11'd3, 10'd0);
    pix(16'd2, 11'd3, 10'd1);
    pix(16'd0, 11'd7, 10'd3);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (bus.blob_valid_out) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      $display("FAIL stall_valid_timeout got 0 expected 1"); errors++;
    end
    for (int c = 0; c < 10; c++) begin
      checks++;
      if (bus.blob_valid_out !== 1'b1 || bus.blob_label_out !== 16'd2 || bus.blob_area_out !== 20'd2 ||
          bus.blob_xmin_out !== 11'd3 || bus.blob_xmax_out !== 11'd3 || bus.blob_ymin_out !== 10'd0 ||
          bus.blob_ymax_out !== 10'd1 || bus.blob_xsum_out !== 31'd6 || bus.blob_ysum_out !== 30'd1) begin
        $display("FAIL stall_hold cycle=%0d valid=%b l=%0d a=%0d xs=%0d ys=%0d expected 1 l=2 a=2 xs=6 ys=1",
                 c, bus.blob_valid_out, bus.blob_label_out, bus.blob_area_out, bus.blob_xsum_out, bus.blob_ysum_out);
        errors++;
      end
      @(negedge clk);
    end
    bus.blob_ready_in = 1'b1;
    run_drain(300);
    checks++;
    if (!done_seen || done_count !== 16'd1 || nrec != 1 || rec_label[0] !== 16'd2) begin
      $display("FAIL stall_release seen=%0d count=%0d nrec=%0d label=%0d expected 1/1/1/2",
               done_seen, done_count, nrec, rec_label[0]); errors++;
    end
  endtask

  task automatic test_label_ovf;
    pix(16'd100, 11'd0, 10'd0);
    pix(16'd7, 11'd1, 10'd0);
    pix(16'd7, 11'd2, 10'd0);
    pix(16'd0, 11'd7, 10'd3);
    checks++;
    if (bus.label_ovf_out !== 1'b1) begin
      $display("FAIL ovf_set got %b expected 1", bus.label_ovf_out); errors++;
    end
    run_drain(300);
    checks++;
    if (ovf_dropped || ovf_at_done !== 1'b0) begin
      $display("FAIL ovf_hold dropped_in_drain=%0d at_done=%b expected 0/0", ovf_dropped, ovf_at_done); errors++;
    end
    checks++;
    if (!done_seen || done_count !== 16'd1 || nrec != 1 || rec_label[0] !== 16'd7 || rec_area[0] !== 20'd2) begin
      $display("FAIL ovf_records seen=%0d count=%0d nrec=%0d label=%0d area=%0d expected 1/1/1/7/2",
               done_seen, done_count, nrec, rec_label[0], rec_area[0]); errors++;
    end
  endtask

  task automatic test_back_to_back;
    for (int x = 0; x < 8; x++) pix(16'd9, 11'(x), 10'd2);
    pix(16'd0, 11'd7, 10'd3);
    checks++;
    if (bus.overrun_out !== 1'b0) begin
      $display("FAIL overrun_clear got %b expected 0", bus.overrun_out); errors++;
    end
    pix(16'd9, 11'd0, 10'd0);
    run_drain(300);
    checks++;
    if (!done_seen || nrec != 1 || rec_label[0] !== 16'd9 || rec_area[0] !== 20'd8 || rec_xmin[0] !== 11'd0 ||
        rec_xmax[0] !== 11'd7 || rec_ymin[0] !== 10'd2 || rec_ymax[0] !== 10'd2 ||
        rec_xsum[0] !== 31'd28 || rec_ysum[0] !== 30'd16) begin
      $display("FAIL b2b_record seen=%0d nrec=%0d l=%0d a=%0d x=%0d..%0d xs=%0d ys=%0d expected l=9 a=8 x=0..7 xs=28 ys=16",
               done_seen, nrec, rec_label[0], rec_area[0], rec_xmin[0], rec_xmax[0], rec_xsum[0], rec_ysum[0]);
      errors++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.overrun_out !== 1'b1) begin
      $display("FAIL overrun_sticky got %b expected 1", bus.overrun_out); errors++;
    end
  endtask

  task automatic test_reset_mid_drain;
    bit seen;
    bus.blob_ready_in = 1'b0;
    pix(16'd4, 11'd0, 10'd0);
    pix(16'd4, 11'd1, 10'd0);
    pix(16'd0, 11'd7, 10'd3);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      if (bus.blob_valid_out) seen = 1;
      else @(negedge clk);
    end
    checks++;
    if (!seen) begin
      $display("FAIL rst_drain_valid_timeout got 0 expected 1"); errors++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.blob_valid_out !== 1'b0 || bus.busy_out !== 1'b0 || bus.overrun_out !== 1'b0 ||
        bus.blob_count_out !== 16'd0 || bus.blob_label_out !== 16'd0 || bus.blob_area_out !== 20'd0) begin
      $display("FAIL rst_drain_outputs valid=%b busy=%b ovr=%b cnt=%0d lbl=%0d area=%0d expected all 0",
               bus.blob_valid_out, bus.busy_out, bus.overrun_out, bus.blob_count_out,
               bus.blob_label_out, bus.blob_area_out); errors++;
    end
    @(negedge clk);
    rst_n = 1'b1;
    bus.blob_ready_in = 1'b1;
    @(negedge clk);
    pix(16'd4, 11'd2, 10'd1);
    pix(16'd4, 11'd3, 10'd1);
    pix(16'd4, 11'd4, 10'd1);
    pix(16'd0, 11'd7, 10'd3);
    run_drain(300);
    checks++;
    if (!done_seen || done_count !== 16'd1 || nrec != 1 || rec_label[0] !== 16'd4 || rec_area[0] !== 20'd3 ||
        rec_xmin[0] !== 11'd2 || rec_xmax[0] !== 11'd4 || rec_ymin[0] !== 10'd1 || rec_ymax[0] !== 10'd1 ||
        rec_xsum[0] !== 31'd9 || rec_ysum[0] !== 30'd3) begin
      $display("FAIL post_reset_frame seen=%0d cnt=%0d nrec=%0d l=%0d a=%0d xs=%0d ys=%0d expected l=4 a=3 xs=9 ys=3",
               done_seen, done_count, nrec, rec_label[0], rec_area[0], rec_xsum[0], rec_ysum[0]);
      errors++;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.label_in = '0;
    bus.hcount_in = '0;
    bus.vcount_in = '0;
    bus.valid_in = 1'b0;
    bus.blob_ready_in = 1'b1;
    #12;
    test_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    test_single_blob();
    test_empty_frame();
    test_min_area();
    test_backpressure();
    test_label_ovf();
    test_back_to_back();
    test_reset_mid_drain();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
